// File: rtl/circular_dma_mm2s.sv
// circular_dma_mm2s
//   Drains a memory ring buffer through an AXI DataMover MM2S channel.
//   The producer's progress arrives as a byte offset (write_ptr). Reads are
//   issued in bursts of at most C_MAX_BURST beats that never cross the ring
//   end. Returned data is forwarded unbuffered to m_axis. read_ptr advances
//   only when the matching DataMover status comes back clean.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   enable                     run/stop (sampled in IDLE and ERROR only)
//   mem_base, mem_size         ring base address and size in bytes
//   write_ptr                  producer offset in bytes
//   read_ptr, bytes_read       consumer offset, running byte total
//   irq                        sticky error flag, cleared by enable=0
//   busy                       high whenever the FSM is not in IDLE
//   m_axis_mm2s_cmd_*          DataMover command stream
//   s_axis_mm2s_sts_*          DataMover status stream
//   s_axis_mm2s_*              read data from DataMover
//   m_axis_*                   delivered data stream
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | compute next burst; clear pointers while disabled
// S_CMD   | present registered command until accepted
// S_DATA  | combinational pass-through of read data until tlast
// S_STS   | wait for status; advance pointers on a clean, tag-matched one
// S_ERROR | irq high, no commands; leave when enable drops
module circular_dma_mm2s #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [C_ADDR_WIDTH-1:0]   mem_base,
  input  logic [31:0]               mem_size,
  input  logic [31:0]               write_ptr,
  output logic [31:0]               read_ptr,
  output logic [31:0]               bytes_read,
  output logic                      irq,
  output logic                      busy,
  output logic [C_ADDR_WIDTH+47:0]  m_axis_mm2s_cmd_tdata,
  output logic                      m_axis_mm2s_cmd_tvalid,
  input  logic                      m_axis_mm2s_cmd_tready,
  input  logic [7:0]                s_axis_mm2s_sts_tdata,
  input  logic                      s_axis_mm2s_sts_tkeep,
  input  logic                      s_axis_mm2s_sts_tlast,
  input  logic                      s_axis_mm2s_sts_tvalid,
  output logic                      s_axis_mm2s_sts_tready,
  input  logic [C_AXIS_WIDTH-1:0]   s_axis_mm2s_tdata,
  input  logic                      s_axis_mm2s_tlast,
  input  logic                      s_axis_mm2s_tvalid,
  output logic                      s_axis_mm2s_tready,
  output logic [C_AXIS_WIDTH-1:0]   m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam logic [31:0] BEAT  = 32'(C_AXIS_WIDTH / 8);
  localparam logic [31:0] CHUNK = 32'(C_MAX_BURST * (C_AXIS_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_STS,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [31:0]             read_ptr_q;
  logic [31:0]             bytes_read_q;
  logic [31:0]             len_q;
  logic [31:0]             size_q;
  logic [3:0]              tag_cnt;
  logic [3:0]              tag_q;
  logic                    irq_q;
  logic [C_ADDR_WIDTH+47:0] cmd_q;
  logic [C_ADDR_WIDTH+47:0] cmd_w;

  logic [31:0] avail;
  logic [31:0] room;
  logic [31:0] len_raw;
  logic [31:0] len_w;
  logic [31:0] rp_sum;
  logic        launch;
  logic        sts_ok;

  // Status sideband carries nothing this block needs.
  logic unused_sts;
  assign unused_sts = s_axis_mm2s_sts_tkeep ^ s_axis_mm2s_sts_tlast;

  always_comb begin
    avail = (write_ptr >= read_ptr_q) ? (write_ptr - read_ptr_q)
                                      : (mem_size - read_ptr_q + write_ptr);
    room    = mem_size - read_ptr_q;
    len_raw = avail;
    if (CHUNK < len_raw) len_raw = CHUNK;
    if (room < len_raw)  len_raw = room;
    len_w = len_raw & ~(BEAT - 32'd1);
  end

  assign launch = enable && (mem_size != 32'd0) && (len_w != 32'd0);
  assign sts_ok = s_axis_mm2s_sts_tdata[7] &&
                  (s_axis_mm2s_sts_tdata[6:4] == 3'b000) &&
                  (s_axis_mm2s_sts_tdata[3:0] == tag_q);
  assign rp_sum = read_ptr_q + len_q;

  // INCR type, EOF set, everything else reserved zero.
  always_comb begin
    cmd_w = '0;
    cmd_w[22:0] = len_w[22:0];
    cmd_w[23] = 1'b1;
    cmd_w[30] = 1'b1;
    cmd_w[C_ADDR_WIDTH+31:32] = mem_base + C_ADDR_WIDTH'(read_ptr_q);
    cmd_w[C_ADDR_WIDTH+35:C_ADDR_WIDTH+32] = tag_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt              = state;
    m_axis_mm2s_cmd_tvalid = 1'b0;
    s_axis_mm2s_sts_tready = 1'b0;
    s_axis_mm2s_tready     = 1'b0;
    m_axis_tvalid          = 1'b0;
    m_axis_tdata           = '0;
    m_axis_tlast           = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) state_nxt = S_CMD;
      end
      S_CMD: begin
        m_axis_mm2s_cmd_tvalid = 1'b1;
        if (m_axis_mm2s_cmd_tready) state_nxt = S_DATA;
      end
      S_DATA: begin
        m_axis_tvalid      = s_axis_mm2s_tvalid;
        m_axis_tdata       = s_axis_mm2s_tdata;
        m_axis_tlast       = s_axis_mm2s_tlast;
        s_axis_mm2s_tready = m_axis_tready;
        if (s_axis_mm2s_tvalid && m_axis_tready && s_axis_mm2s_tlast)
          state_nxt = S_STS;
      end
      S_STS: begin
        s_axis_mm2s_sts_tready = 1'b1;
        if (s_axis_mm2s_sts_tvalid) state_nxt = sts_ok ? S_IDLE : S_ERROR;
      end
      S_ERROR: begin
        if (!enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_ptr_q   <= '0;
      bytes_read_q <= '0;
      len_q        <= '0;
      size_q       <= '0;
      tag_cnt      <= '0;
      tag_q        <= '0;
      irq_q        <= 1'b0;
      cmd_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            len_q  <= len_w;
            size_q <= mem_size;
            tag_q  <= tag_cnt;
            cmd_q  <= cmd_w;
          end else if (!enable) begin
            read_ptr_q   <= '0;
            bytes_read_q <= '0;
            tag_cnt      <= '0;
          end
        end
        S_CMD: begin
          if (m_axis_mm2s_cmd_tready) tag_cnt <= tag_cnt + 4'd1;
        end
        S_STS: begin
          if (s_axis_mm2s_sts_tvalid) begin
            if (sts_ok) begin
              // Landing exactly on the ring end wraps to offset 0.
              read_ptr_q   <= (rp_sum == size_q) ? 32'd0 : rp_sum;
              bytes_read_q <= bytes_read_q + len_q;
            end else begin
              irq_q <= 1'b1;
            end
          end
        end
        S_ERROR: begin
          if (!enable) irq_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign read_ptr              = read_ptr_q;
  assign bytes_read            = bytes_read_q;
  assign irq                   = irq_q;
  assign busy                  = (state != S_IDLE);
  assign m_axis_mm2s_cmd_tdata = cmd_q;

endmodule

// File: tb/tb_circular_dma_mm2s.sv
module tb_circular_dma_mm2s;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] mem_base = '0;
  logic [31:0] mem_size = '0;
  logic [31:0] write_ptr = '0;
  logic [31:0] read_ptr;
  logic [31:0] bytes_read;
  logic        irq;
  logic        busy;
  logic [79:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready = 1'b1;
  logic [7:0]  sts_tdata = '0;
  logic        sts_tkeep = 1'b1;
  logic        sts_tlast = 1'b1;
  logic        sts_tvalid = 1'b0;
  logic        sts_tready;
  logic [63:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;

  logic [7:0]  sts_force = '0;
  logic        sts_force_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cmd = 0;
  int n_beats = 0;

  circular_dma_mm2s dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .mem_base               (mem_base),
    .mem_size               (mem_size),
    .write_ptr              (write_ptr),
    .read_ptr               (read_ptr),
    .bytes_read             (bytes_read),
    .irq                    (irq),
    .busy                   (busy),
    .m_axis_mm2s_cmd_tdata  (cmd_tdata),
    .m_axis_mm2s_cmd_tvalid (cmd_tvalid),
    .m_axis_mm2s_cmd_tready (cmd_tready),
    .s_axis_mm2s_sts_tdata  (sts_tdata),
    .s_axis_mm2s_sts_tkeep  (sts_tkeep),
    .s_axis_mm2s_sts_tlast  (sts_tlast),
    .s_axis_mm2s_sts_tvalid (sts_tvalid),
    .s_axis_mm2s_sts_tready (sts_tready),
    .s_axis_mm2s_tdata      (s_tdata),
    .s_axis_mm2s_tlast      (s_tlast),
    .s_axis_mm2s_tvalid     (s_tvalid),
    .s_axis_mm2s_tready     (s_tready),
    .m_axis_tdata           (m_tdata),
    .m_axis_tlast           (m_tlast),
    .m_axis_tvalid          (m_tvalid),
    .m_axis_tready          (m_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents as seen by the DataMover: derived from the byte address.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  function automatic logic [31:0] model_len(input logic [31:0] rp, input logic [31:0] wp,
                                            input logic [31:0] size);
    logic [31:0] av, l;
    av = (wp >= rp) ? wp - rp : size - rp + wp;
    l = av;
    if (l > 32'd128) l = 32'd128;
    if (l > size - rp) l = size - rp;
    return l - (l % 32'd8);
  endfunction

  function automatic logic [79:0] cmd_word(input logic [31:0] addr, input logic [31:0] len,
                                           input logic [3:0] tag);
    logic [79:0] w;
    w = '0;
    w[22:0] = len[22:0];
    w[23] = 1'b1;
    w[30] = 1'b1;
    w[63:32] = addr;
    w[67:64] = tag;
    return w;
  endfunction

  // Transaction-level model and per-cycle compare (sampled at negedge).
  initial begin : compare
    logic [31:0] m_rp, m_br, m_len, m_addr, m_size;
    logic [3:0]  m_tag, m_ctag;
    bit          m_out, m_pend, m_data, m_err, p_sts, p_idle, p_err, prev_stall;
    int          m_beat;
    logic [79:0] prev_cmd;
    m_rp = '0; m_br = '0; m_len = '0; m_addr = '0; m_size = '0;
    m_tag = '0; m_ctag = '0; m_out = 0; m_pend = 0; m_data = 0; m_err = 0;
    m_beat = 0; prev_stall = 0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_status", {read_ptr, bytes_read, irq, busy, cmd_tvalid, sts_tready,
                             s_tready, m_tvalid, m_tlast}, '0);
        chk("reset_cmd", cmd_tdata, '0);
        chk("reset_data", m_tdata, '0);
        m_rp = '0; m_br = '0; m_tag = '0; m_out = 0; m_pend = 0; m_data = 0; m_err = 0;
        m_beat = 0; prev_stall = 0;
      end else begin
        p_idle = !m_out && !m_err;
        p_sts  = m_out && !m_pend && !m_data;
        p_err  = m_err;
        chk("read_ptr", read_ptr, m_rp);
        chk("bytes_read", bytes_read, m_br);
        chk("irq", irq, m_err);
        chk("busy", busy, m_out || m_err);
        chk("cmd_tvalid", cmd_tvalid, m_pend);
        if (m_pend) chk("cmd_tdata", cmd_tdata, cmd_word(m_addr, m_len, m_ctag));
        if (prev_stall) chk("cmd_stable", cmd_tdata, prev_cmd);
        prev_stall = cmd_tvalid && !cmd_tready;
        prev_cmd = cmd_tdata;
        chk("sts_tready", sts_tready, p_sts);
        if (m_data) begin
          chk("pass_valid", m_tvalid, s_tvalid);
          chk("pass_ready", s_tready, m_tready);
          chk("pass_data", m_tdata, s_tdata);
          chk("pass_last", m_tlast, s_tlast);
          if (m_tvalid && m_tready) begin
            chk("beat_data", m_tdata, mem_word(m_addr + 32'(8 * m_beat)));
            chk("beat_last", m_tlast, (m_beat == int'(m_len / 8) - 1));
            n_beats++;
            m_beat++;
            if (m_beat == int'(m_len / 8)) m_data = 0;
          end
        end else begin
          chk("bridge_blocked", {m_tvalid, s_tready}, '0);
        end
        if (m_pend && cmd_tready) begin
          m_pend = 0; m_data = 1; m_beat = 0; m_tag = m_tag + 4'd1; n_cmd++;
        end
        if (p_sts && sts_tvalid) begin
          m_out = 0;
          if (sts_tdata[7] && sts_tdata[6:4] == 3'b000 && sts_tdata[3:0] == m_ctag) begin
            m_br = m_br + m_len;
            m_rp = (m_rp + m_len == m_size) ? 32'd0 : m_rp + m_len;
          end else begin
            m_err = 1;
          end
        end
        if (p_idle) begin
          if (enable && mem_size != 0 && model_len(m_rp, write_ptr, mem_size) != 0) begin
            m_out = 1; m_pend = 1;
            m_len = model_len(m_rp, write_ptr, mem_size);
            m_addr = mem_base + m_rp;
            m_ctag = m_tag;
            m_size = mem_size;
          end else if (!enable) begin
            m_rp = '0; m_br = '0; m_tag = '0;
          end
        end else if (p_err && !enable) begin
          m_err = 0;
        end
      end
    end
  end

  // DataMover emulator: accepts commands, returns memory words, then status.
  initial begin : dm_emu
    logic [79:0] cw;
    bit          c_hs, d_hs, s_hs, act;
    logic [31:0] e_addr;
    logic [3:0]  e_tag;
    int          e_n, e_i, gap;
    act = 0; gap = 0; e_n = 0; e_i = 0; e_addr = '0; e_tag = '0;
    forever begin
      @(negedge clk);
      c_hs = cmd_tvalid && cmd_tready;
      d_hs = s_tvalid && s_tready;
      s_hs = sts_tvalid && sts_tready;
      cw = cmd_tdata;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        act = 0; s_tvalid = 0; s_tlast = 0; sts_tvalid = 0;
      end else begin
        if (s_hs) sts_tvalid = 0;
        if (d_hs) begin
          e_i++;
          if (e_i == e_n) begin
            act = 0; s_tvalid = 0; s_tlast = 0;
            sts_tvalid = 1;
            sts_tdata = sts_force_en ? sts_force : {4'b1000, e_tag};
          end
        end
        if (c_hs) begin
          act = 1; e_addr = cw[63:32]; e_tag = cw[67:64];
          e_n = int'(cw[22:0]) / 8; e_i = 0;
        end
        if (act) begin
          gap++;
          s_tvalid = (gap % 5 != 0);
          s_tdata = mem_word(e_addr + 32'(8 * e_i));
          s_tlast = (e_i == e_n - 1);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rp(input logic [31:0] t, input int lim, input string name);
    int i;
    i = 0;
    while (read_ptr !== t && i < lim) begin tick(); i++; end
    chk(name, read_ptr, t);
  endtask

  task automatic wait_cmd(input int lim, input string name);
    int i;
    i = 0;
    while (cmd_tvalid !== 1'b1 && i < lim) begin tick(); i++; end
    chk(name, cmd_tvalid, 1'b1);
  endtask

  task automatic wait_irq(input int lim, input string name);
    int i;
    i = 0;
    while (irq !== 1'b1 && i < lim) begin tick(); i++; end
    chk(name, irq, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int lim, input string name);
    int i;
    i = 0;
    while (n_beats < target && i < lim) begin tick(); i++; end
    chk(name, n_beats >= target, 1'b1);
  endtask

  initial begin : main
    int c0, b0;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_read_ptr", read_ptr, 32'h0);
    chk("rst_flags", {busy, irq, cmd_tvalid}, 3'b000);
    rst_n = 1'b1;
    mem_base = BASE; mem_size = SIZE; write_ptr = 32'h40; enable = 1'b1;

    // Single burst
    b0 = n_beats;
    wait_cmd(20, "t1_cmd_seen");
    chk("t1_cmd_word", cmd_tdata, 80'h0000_1000_0000_4080_0040);
    wait_rp(32'h40, 200, "t1_read_ptr");
    chk("t1_bytes_read", bytes_read, 32'h40);
    chk("t1_beats", n_beats - b0, 8);

    // Disable clears pointers; chunking from 0 with command stall and backpressure
    enable = 1'b0;
    tick(4);
    chk("t2_disabled_ptrs", {read_ptr, bytes_read}, 64'h0);
    cmd_tready = 1'b0; write_ptr = 32'h200; enable = 1'b1;
    c0 = n_cmd; b0 = n_beats;
    wait_cmd(20, "t2_cmd_seen");
    tick(3);
    chk("t5_cmd_held", cmd_tdata, 80'h0000_1000_0000_4080_0080);
    cmd_tready = 1'b1;
    wait_beats(b0 + 3, 100, "t5_beats_started");
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_s_tready_low", s_tready, 1'b0);
    end
    m_tready = 1'b1;
    wait_rp(32'h200, 800, "t2_read_ptr");
    chk("t2_cmd_count", n_cmd - c0, 4);
    chk("t2_beats", n_beats - b0, 64);
    chk("t2_bytes_read", bytes_read, 32'h200);

    // Wrap around the ring end
    write_ptr = 32'hFC0;
    wait_rp(32'hFC0, 3000, "t3_reach_fc0");
    write_ptr = 32'h40;
    wait_cmd(20, "t3_wrap_cmd_seen");
    chk("t3_wrap_cmd", cmd_tdata, 80'h0000_1000_0FC0_4080_0040);
    wait_rp(32'h0, 200, "t3_rp_wrapped");
    wait_cmd(20, "t3_next_cmd_seen");
    chk("t3_next_cmd", cmd_tdata, 80'h0001_1000_0000_4080_0040);
    wait_rp(32'h40, 200, "t3_rp_after");

    // Error: SLVERR status
    sts_force = 8'hC0; sts_force_en = 1'b1; write_ptr = 32'h80;
    wait_irq(200, "t4_irq_slverr");
    sts_force_en = 1'b0;
    chk("t4_rp_held", read_ptr, 32'h40);
    c0 = n_cmd;
    tick(10);
    chk("t4_no_cmds", n_cmd - c0, 0);
    chk("t4_irq_sticky", {irq, busy}, 2'b11);
    enable = 1'b0;
    tick(3);
    chk("t4_irq_cleared", irq, 1'b0);
    chk("t4_rp_cleared", read_ptr, 32'h0);

    // Error: tag mismatch
    sts_force = 8'h81; sts_force_en = 1'b1; enable = 1'b1;
    wait_irq(200, "t4_irq_tag");
    sts_force_en = 1'b0;
    chk("t4_tag_rp_held", read_ptr, 32'h0);
    enable = 1'b0;
    tick(3);
    chk("t4_tag_irq_cleared", irq, 1'b0);

    // Reset during the fourth beat
    write_ptr = 32'h40; enable = 1'b1;
    b0 = n_beats;
    wait_beats(b0 + 3, 100, "t6_beats_started");
    rst_n = 1'b0;
    #1;
    chk("t6_async_status", {busy, irq, cmd_tvalid, sts_tready, s_tready, m_tvalid, m_tlast}, '0);
    chk("t6_async_data", m_tdata, '0);
    chk("t6_async_ptrs", {read_ptr, bytes_read}, '0);
    tick(2);
    rst_n = 1'b1;
    wait_cmd(20, "t6_cmd_seen");
    chk("t6_fresh_cmd", cmd_tdata, 80'h0000_1000_0000_4080_0040);
    wait_rp(32'h40, 200, "t6_read_ptr");
    chk("t6_bytes_read", bytes_read, 32'h40);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/circular_dma_mm2s.md
# circular_dma_mm2s

Circular DMA reader for use with an AXI DataMover MM2S channel. It drains a ring buffer in memory that a producer fills, with the producer's progress given as a byte offset. It issues DataMover read commands in bursts that never cross the ring end. It forwards the returned data on an output AXI-Stream and advances its read pointer when the matching DataMover status arrives. It sits beside the S2MM circular DMA FSM and is driven by the same register-block outputs (enable, mem_base, mem_size).

## Interface
- C_ADDR_WIDTH, 32, DataMover address width.
- C_AXIS_WIDTH, 64, data stream width in bits; BEAT = C_AXIS_WIDTH/8 bytes.
- C_MAX_BURST, 16, maximum beats per command; CHUNK = C_MAX_BURST*BEAT bytes (128 by default).
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run/stop.
- mem_base  in  C_ADDR_WIDTH  ring base address.
- mem_size  in  32  ring size in bytes, a multiple of BEAT.
- write_ptr  in  32  producer offset in bytes, a multiple of BEAT, less than mem_size.
- read_ptr  out  32  consumer offset in bytes.
- bytes_read  out  32  total bytes delivered, wraps modulo 2^32.
- irq  out  1  error flag, sticky.
- busy  out  1  high in any state other than IDLE.
- m_axis_mm2s_cmd_tdata  out  C_ADDR_WIDTH+48  DataMover command.
- m_axis_mm2s_cmd_tvalid  out  1.
- m_axis_mm2s_cmd_tready  in  1.
- s_axis_mm2s_sts_tdata  in  8  DataMover status.
- s_axis_mm2s_sts_tkeep  in  1.
- s_axis_mm2s_sts_tlast  in  1.
- s_axis_mm2s_sts_tvalid  in  1.
- s_axis_mm2s_sts_tready  out  1.
- s_axis_mm2s_tdata / tlast / tvalid  in  C_AXIS_WIDTH/1/1  read data from the DataMover.
- s_axis_mm2s_tready  out  1.
- m_axis_tdata / tlast / tvalid  out  C_AXIS_WIDTH/1/1  delivered data.
- m_axis_tready  in  1.

## Operation
- **avail**: write_ptr − read_ptr if write_ptr ≥ read_ptr, otherwise mem_size − read_ptr + write_ptr. 32-bit unsigned.
- **len**: min(avail, CHUNK, mem_size − read_ptr), rounded down to a multiple of BEAT.
- **States**:
  - IDLE: if enable and mem_size≠0 and len≠0, register len, address = mem_base + read_ptr, tag = tag_cnt, then go to CMD.
  - CMD: cmd_tvalid=1. On handshake, tag_cnt++ (4-bit, wraps), then go to DATA.
  - DATA: pass-through, m_axis_tvalid = s_axis_mm2s_tvalid and s_axis_mm2s_tready = m_axis_tready, with tdata and tlast forwarded. On an accepted beat with tlast, go to STS. The bridge is fully blocked outside DATA.
  - STS: sts_tready=1. On sts handshake: if tdata[7]=1, tdata[6:4]=0 and tdata[3:0]=tag, then read_ptr += len (→0 if result == mem_size), bytes_read += len, and go to IDLE. Otherwise go to ERROR.
  - ERROR: irq=1 and no commands. When enable=0, go to IDLE and clear irq.
- **Command word**:
  - [22:0] = len
  - [23] = 1 (INCR)
  - [29:24] = 0
  - [30] = 1 (EOF)
  - [31] = 0
  - [C_ADDR_WIDTH+31:32] = address
  - [C_ADDR_WIDTH+35:C_ADDR_WIDTH+32] = tag
  - upper bits = 0
- **Disable**: enable is sampled only in IDLE/ERROR, so an in-flight command completes through STS. While enable=0 in IDLE, read_ptr, bytes_read and tag_cnt are held at 0. Restarting from enable=0 therefore begins at offset 0.
- **Inputs**: write_ptr and mem_size are sampled only in IDLE. Changing mem_size while enabled is unsupported.
- **Empty/full**: write_ptr == read_ptr means empty; no command is issued. The producer keeps at least BEAT bytes free, so the ring is never "full".

## Timing
- Reset: all outputs are 0, state IDLE, tag_cnt 0. Reset is asynchronous and takes effect mid-transfer with no drain.
- IDLE→CMD takes 1 cycle. cmd_tvalid rises the cycle after the IDLE evaluation.
- cmd_tdata is registered and stays stable while tvalid=1 and tready=0.
- DATA adds zero latency: combinational pass-through with no buffering.
- read_ptr and bytes_read update on the clock edge of the status handshake, visible the next cycle.
- Back-to-back minimum: status handshake → IDLE (1) → CMD (1), so 2 cycles between a status and the next cmd_tvalid.
- irq rises 1 cycle after an erroneous status handshake.

## Test plan
1. **Single burst**: mem_base=0x1000_0000, mem_size=0x1000, write_ptr=0x40, enable=1. Expect one cmd with len=0x40, addr=0x1000_0000, tag=0, bit23=1, bit30=1. Expect 8 beats out with tlast on the 8th. After status 0x80, read_ptr=0x40 and bytes_read=0x40.
2. **Chunking**: write_ptr=0x200 from 0. Expect 4 commands with len=0x80 at +0/+0x80/+0x100/+0x180 and tags 0..3. Final read_ptr=0x200.
3. **Wrap**: reach read_ptr=0xFC0, then set write_ptr=0x40. Expect cmd len=0x40 at base+0xFC0, then read_ptr=0. Expect cmd len=0x40 at base+0, then read_ptr=0x40.
4. **Error**: return status 0xC0 (SLVERR), or 0x81 with expected tag 0. Expect irq=1, read_ptr unchanged, no further commands. After enable=0, irq=0 and read_ptr=0.
5. **Backpressure**: hold m_axis_tready=0 for 5 cycles mid-burst. Expect s_axis_mm2s_tready=0 in those cycles and no beat lost or duplicated. Hold cmd_tready=0 for 3 cycles. Expect cmd_tdata stable throughout.
6. **Reset mid-DATA**: assert rst_n=0 during beat 4. Expect all outputs 0 immediately. After release with enable=1 and write_ptr=0x40, a fresh cmd is issued with tag=0 at offset 0.
